// File: rtl/gray_counter_updown_pkg.sv
// gray_counter_updown_pkg: mode constants and Gray/binary helper functions
package gray_counter_updown_pkg;

   localparam int GRAY_WRAP = 0;
   localparam int GRAY_SAT  = 1;

   function automatic logic [31:0] bin2gray(input logic [31:0] x);
      return x ^ (x >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits from the MSB down to it
   function automatic logic [31:0] gray2bin(input logic [31:0] x);
      logic [31:0] r;
      r = x;
      for (int i = 1; i < 32; i++) r = r ^ (x >> i);
      return r;
   endfunction

endpackage

// File: rtl/gray_counter_updown_gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter for the load path
module gray2bin_conv #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Prefix XOR from the MSB, written per bit so there is no combinational chain on bin itself
   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/gray_counter_updown.sv
// gray_counter_updown: parametrised up/down Gray counter with load, saturate mode and Mealy tc; GRAY_CNT_BIN_OUT_EN adds bin_out
import gray_counter_updown_pkg::*;

module gray_counter_updown #(
   parameter int WIDTH    = 3,
   parameter int SATURATE = GRAY_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             upNotDown,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] salida,
`ifdef GRAY_CNT_BIN_OUT_EN
   output logic [WIDTH-1:0] bin_out,
`endif
   output logic             tc
);

   logic [WIDTH-1:0] bin, g, next_bin, load_bin, step;
   logic             term, sat_hold;

   gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
      .gray(load_value),
      .bin (load_bin)
   );

   // Next binary value: load beats counting, saturate mode freezes at the terminal value
   always_comb begin
      term     = upNotDown ? (bin == '1) : (bin == '0);
      sat_hold = (SATURATE == GRAY_SAT) && term;
      step     = upNotDown ? bin + 1'b1 : bin - 1'b1;
      next_bin = load ? load_bin : (en && !sat_hold) ? step : bin;
      tc       = en & ~load & ~reset & term;
   end

   // Binary and Gray registers move together so salida is a clean registered Gray code
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin <= '0;
         g   <= '0;
      end else begin
         bin <= next_bin;
         g   <= next_bin ^ (next_bin >> 1);
      end
   end

   assign salida = g;
`ifdef GRAY_CNT_BIN_OUT_EN
   assign bin_out = bin;
`endif

endmodule

// File: tb/tb_gray_counter_updown.sv
// tb_gray_counter_updown: table-driven directed checks plus corner sequences and a randomised model run
import gray_counter_updown_pkg::*;

module tb_gray_counter_updown;

   typedef struct {
      logic       en, ud, ld;
      logic [2:0] lv, exp_s;
      logic       exp_tc;
   } vec_t;

   logic       clk = 0, reset;
   logic       en, ud, ld;
   logic [2:0] lv, s3, ss;
   logic       tc3, tcs;
   logic       en8, ud8, ld8, tc8;
   logic [7:0] lv8, s8;
`ifdef GRAY_CNT_BIN_OUT_EN
   logic [2:0] b3, bs;
   logic [7:0] b8;
`endif
   int         total = 0, bad = 0;
   vec_t       vt[$];

   always #5 clk = ~clk;

   gray_counter_updown #(.WIDTH(3), .SATURATE(GRAY_WRAP)) u3 (
      .clk(clk), .reset(reset), .en(en), .upNotDown(ud), .load(ld), .load_value(lv),
      .salida(s3),
`ifdef GRAY_CNT_BIN_OUT_EN
      .bin_out(b3),
`endif
      .tc(tc3));

   gray_counter_updown #(.WIDTH(3), .SATURATE(GRAY_SAT)) us (
      .clk(clk), .reset(reset), .en(en), .upNotDown(ud), .load(ld), .load_value(lv),
      .salida(ss),
`ifdef GRAY_CNT_BIN_OUT_EN
      .bin_out(bs),
`endif
      .tc(tcs));

   gray_counter_updown #(.WIDTH(8), .SATURATE(GRAY_WRAP)) u8 (
      .clk(clk), .reset(reset), .en(en8), .upNotDown(ud8), .load(ld8), .load_value(lv8),
      .salida(s8),
`ifdef GRAY_CNT_BIN_OUT_EN
      .bin_out(b8),
`endif
      .tc(tc8));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [7:0] m, nm, prev;
      logic       stepped;
      // en, ud, ld, lv, expected salida before the edge, expected tc
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b011, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b110, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b101, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b1});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0});
      vt.push_back('{1'b0, 1'b0, 1'b0, 3'b000, 3'b101, 1'b0});
      vt.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 3'b101, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 3'b110, 3'b101, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b110, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 3'b100, 3'b111, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 3'b000, 3'b100, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1});
      vt.push_back('{1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0});

      reset = 1; en = 1; ud = 0; ld = 0; lv = 0;
      en8 = 0; ud8 = 0; ld8 = 0; lv8 = 0;
      #2;
      chk("reset_salida", 32'(s3), 0);
      chk("reset_tc", 32'(tc3), 0);
      chk("reset_sat_salida", 32'(ss), 0);
      @(negedge clk);
      reset = 0;

      foreach (vt[i]) begin
         en = vt[i].en; ud = vt[i].ud; ld = vt[i].ld; lv = vt[i].lv;
         #1;
         chk($sformatf("vec%0d_salida", i), 32'(s3), 32'(vt[i].exp_s));
         chk($sformatf("vec%0d_tc", i), 32'(tc3), 32'(vt[i].exp_tc));
         @(negedge clk);
      end

      reset = 1; ld = 0; en = 1; ud = 1;
      #1;
      chk("sat_reset", 32'(ss), 0);
      reset = 0;
      repeat (10) @(negedge clk);
      chk("sat_hold_salida", 32'(ss), 32'b100);
      chk("sat_hold_tc", 32'(tcs), 1);
      ud = 0;
      #1;
      chk("sat_dirflip_tc", 32'(tcs), 0);
      @(negedge clk);
      chk("sat_down_salida", 32'(ss), 32'b101);

      reset = 1;
      #1;
      reset = 0; en = 1; ud = 1;
      repeat (2) @(negedge clk);
      chk("pre_async_salida", 32'(s3), 32'b011);
      ud = 0;
      #2;
      reset = 1;
      #1;
      chk("async_reset_salida", 32'(s3), 0);
      chk("async_reset_tc", 32'(tc3), 0);
      @(negedge clk);
      reset = 0; ud = 1;
      @(negedge clk);
      chk("restart_salida", 32'(s3), 32'b001);

      en = 0;
      m = 0;
      for (int i = 0; i < 10000; i++) begin
         en8 = $urandom_range(0, 3) != 0;
         ud8 = 1'($urandom_range(0, 1));
         ld8 = $urandom_range(0, 15) == 0;
         lv8 = 8'($urandom);
         #1;
         chk("rand_tc", 32'(tc8), 32'(en8 & ~ld8 & (ud8 ? (m == 8'hff) : (m == 8'h00))));
         prev = s8;
         stepped = en8 & ~ld8;
         nm = ld8 ? 8'(gray2bin(32'(lv8))) : en8 ? (ud8 ? m + 8'd1 : m - 8'd1) : m;
         @(negedge clk);
         m = nm;
         chk("rand_salida", 32'(s8), bin2gray(32'(m)));
         if (stepped) chk("rand_onebit", $countones(s8 ^ prev), 1);
`ifdef GRAY_CNT_BIN_OUT_EN
         chk("rand_bin_out", 32'(b8), 32'(m));
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
